mem_stage_lsu: RTL and testbench
================================

Name: mem_stage_lsu

Overview:
- Load/store unit for the MEM stage. It consumes the M-side outputs of the EX/MEM pipeline register and runs the data-memory request/response handshake.
- Generates byte enables and write-data lane replication for stores, and extracts and sign/zero-extends load data.
- Asserts StallM to freeze IF–M while an access is outstanding.
- Its output feeds the MEM/WB register.

Parameters:
- XLEN, 32: datapath width. Only 32 is supported (4 byte lanes).
- RESULT_SRC_LOAD, 3'b001: ResultSrcM encoding that marks a load.
- TIMEOUT_CYCLES, 256: watchdog limit in cycles. Used only with LSU_TIMEOUT_EN.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- MemWriteM  input  1  store in M stage.
- ResultSrcM  input  3  load when equal to RESULT_SRC_LOAD.
- ALUResultM  input  XLEN  effective address.
- WriteDataM  input  XLEN  store data (rs2).
- funct3M  input  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- dmem_req  output  1  request valid.
- dmem_we  output  1  1 = store.
- dmem_addr  output  XLEN  word-aligned address ({addr[31:2],2'b00}).
- dmem_wdata  output  XLEN  lane-replicated store data.
- dmem_be  output  4  byte enables.
- dmem_gnt  input  1  memory accepts request this cycle.
- dmem_rvalid  input  1  load response valid.
- dmem_rdata  input  XLEN  load response word.
- ReadDataM  output  XLEN  extended load data; valid only when LoadDoneM=1, else 0.
- LoadDoneM  output  1  load completes this cycle.
- StallM  output  1  hold pipeline (IF–M).
- FaultM  output  1  one-cycle pulse on misaligned access, illegal funct3 or timeout.

Behaviour:
- Access present: MemWriteM=1, or ResultSrcM==RESULT_SRC_LOAD. If both are set, treat as a store.
- Reset values:
  - FSM in IDLE; all captured request registers cleared.
  - dmem_req, dmem_we, dmem_be, dmem_addr and dmem_wdata are 0.
  - StallM, LoadDoneM, FaultM and ReadDataM are 0 while no access is present.
- FSM states:
  - IDLE: drives the request combinationally from M inputs.
    - Access present and legal → dmem_req=1.
    - Store with dmem_gnt → stays IDLE, StallM=0 (zero-stall store).
    - Store without dmem_gnt → captures the request into registers → REQ, StallM=1.
    - Load with dmem_gnt → WAIT, StallM=1.
    - Load without dmem_gnt → capture → REQ, StallM=1.
  - REQ: drives the captured request; it must stay stable until gnt. StallM=1.
    - On gnt, a store → IDLE with StallM=0 in the gnt cycle; a load → WAIT.
  - WAIT: dmem_req=0; StallM=1 until dmem_rvalid.
    - In the rvalid cycle: LoadDoneM=1, ReadDataM=extended dmem_rdata, StallM=0 → IDLE.
    - The pipeline advances at that edge, so the next M instruction is seen in IDLE.
- dmem_rvalid is ignored in IDLE and REQ. Minimum load latency is 1 stall cycle.
- Misalignment (checked in IDLE, no request issued):
  - w with addr[1:0]≠0, h/hu with addr[0]≠0, or funct3 ∈ {011,110,111}.
  - Store funct3 other than 000/001/010 is also illegal.
  - Response: FaultM=1 for one cycle, StallM=0, LoadDoneM=0, ReadDataM=0, stay IDLE.
- Store lanes:
  - sb: be = 4'b0001<<addr[1:0], wdata = {4{wd[7:0]}}.
  - sh: be = 4'b0011<<{addr[1],1'b0}, wdata = {2{wd[15:0]}}.
  - sw: be = 4'b1111, wdata = wd.
- Loads use dmem_be=4'b1111. Byte/half lane is selected by the captured addr[1:0]:
  - b: sign-extend byte.
  - bu: zero-extend byte.
  - h/hu: sign/zero-extend half at addr[1].
  - w: word unchanged.
- Captured registers (addr low bits, funct3, we, be, wdata) are loaded on leaving IDLE. They are used in REQ and WAIT, independent of M inputs.
- Reset mid-operation forces IDLE and drops dmem_req the next cycle. A late dmem_rvalid after reset is ignored.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- With the macro defined:
  - A counter resets on entry to REQ/WAIT and increments each cycle spent there.
  - On reaching TIMEOUT_CYCLES with no gnt/rvalid, the FSM aborts to IDLE: dmem_req=0, FaultM=1 for one cycle, StallM=0, LoadDoneM=0.
  - A subsequent stray rvalid is ignored.
- Without the macro: no counter; the FSM waits indefinitely.

Test Plan:
- sb to addr 0x1003, data 0x000000A5, gnt same cycle → dmem_be=4'b1000, dmem_wdata=0xA5A5A5A5, dmem_addr=0x1000, StallM=0, state IDLE.
- lh addr 0x2002, gnt after 2 cycles, rvalid 3 cycles later with rdata=0x8001_1234 → StallM=1 for 5 cycles, request stable during REQ, then LoadDoneM=1, ReadDataM=0xFFFF8001, StallM=0.
- lbu addr 0x31, rdata=0x0000F000 → ReadDataM=0x000000F0; lb same → 0xFFFFFFF0.
- lw addr 0x4002 → no dmem_req, FaultM pulse 1 cycle, StallM=0; funct3=011 load → same.
- Load in WAIT, reset asserted, then rvalid one cycle later → dmem_req=0, LoadDoneM=0, all outputs at reset values.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=8: load, gnt never asserted → StallM=1 for 8 cycles, then FaultM=1, StallM=0, IDLE; without the macro StallM stays 1.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: drives the data-memory handshake and aligns and extends load data.
// Optional feature: define LSU_TIMEOUT_EN to abort REQ/WAIT after TIMEOUT_CYCLES with a fault.
module mem_stage_lsu #(
    parameter int unsigned XLEN            = 32,
    parameter logic [2:0]  RESULT_SRC_LOAD = 3'b001,
    parameter int unsigned TIMEOUT_CYCLES  = 256
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            MemWriteM,
    input  logic [2:0]      ResultSrcM,
    input  logic [XLEN-1:0] ALUResultM,
    input  logic [XLEN-1:0] WriteDataM,
    input  logic [2:0]      funct3M,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_be,
    input  logic            dmem_gnt,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic [XLEN-1:0] ReadDataM,
    output logic            LoadDoneM,
    output logic            StallM,
    output logic            FaultM
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_state_next;
    logic [XLEN-1:0] r_addr;
    logic [1:0]      r_addr_lo;
    logic [2:0]      r_funct3;
    logic            r_we;
    logic [3:0]      r_be;
    logic [XLEN-1:0] r_wdata;

    logic            w_is_store;
    logic            w_is_load;
    logic            w_access;
    logic            w_illegal;
    logic            w_capture;
    logic            w_timeout;
    logic [3:0]      w_be;
    logic [XLEN-1:0] w_wdata;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [XLEN-1:0] w_load_ext;

    // A store wins when both MemWriteM and the load encoding are present.
    assign w_is_store = MemWriteM;
    assign w_is_load  = !MemWriteM && (ResultSrcM == RESULT_SRC_LOAD);
    assign w_access   = w_is_store || w_is_load;

    always_comb begin
        w_illegal = 1'b0;
        case (funct3M)
            3'b000, 3'b100: w_illegal = w_is_store && funct3M[2];
            3'b001, 3'b101: w_illegal = ALUResultM[0] || (w_is_store && funct3M[2]);
            3'b010:         w_illegal = |ALUResultM[1:0];
            default:        w_illegal = 1'b1;
        endcase
    end

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = '0;
        if (w_is_store) begin
            case (funct3M[1:0])
                2'b00: begin
                    w_be    = 4'b0001 << ALUResultM[1:0];
                    w_wdata = {4{WriteDataM[7:0]}};
                end
                2'b01: begin
                    w_be    = 4'b0011 << {ALUResultM[1], 1'b0};
                    w_wdata = {2{WriteDataM[15:0]}};
                end
                default: begin
                    w_be    = 4'b1111;
                    w_wdata = WriteDataM;
                end
            endcase
        end
    end

    // Lane selection uses the captured offset, never the live M-stage address.
    always_comb begin
        case (r_addr_lo)
            2'b00:   w_byte = dmem_rdata[7:0];
            2'b01:   w_byte = dmem_rdata[15:8];
            2'b10:   w_byte = dmem_rdata[23:16];
            default: w_byte = dmem_rdata[31:24];
        endcase
        w_half = r_addr_lo[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (r_funct3)
            3'b000:  w_load_ext = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load_ext = {24'd0, w_byte};
            3'b001:  w_load_ext = {{16{w_half[15]}}, w_half};
            3'b101:  w_load_ext = {16'd0, w_half};
            default: w_load_ext = dmem_rdata;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || (r_state != w_state_next) || (r_state == S_IDLE)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
    assign w_timeout        = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        dmem_addr    = '0;
        dmem_wdata   = '0;
        dmem_be      = 4'b0000;
        StallM       = 1'b0;
        LoadDoneM    = 1'b0;
        FaultM       = 1'b0;
        ReadDataM    = '0;
        case (r_state)
            S_IDLE: begin
                if (w_access && !w_illegal) begin
                    dmem_req   = 1'b1;
                    dmem_we    = w_is_store;
                    dmem_addr  = {ALUResultM[XLEN-1:2], 2'b00};
                    dmem_be    = w_be;
                    dmem_wdata = w_wdata;
                    if (!(w_is_store && dmem_gnt)) begin
                        w_capture    = 1'b1;
                        StallM       = 1'b1;
                        w_state_next = (w_is_load && dmem_gnt) ? S_WAIT : S_REQ;
                    end
                end else if (w_access) begin
                    FaultM = 1'b1;
                end
            end
            S_REQ: begin
                if (w_timeout && !dmem_gnt) begin
                    FaultM       = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    dmem_req   = 1'b1;
                    dmem_we    = r_we;
                    dmem_addr  = r_addr;
                    dmem_be    = r_be;
                    dmem_wdata = r_wdata;
                    StallM     = !(dmem_gnt && r_we);
                    if (dmem_gnt) begin
                        w_state_next = r_we ? S_IDLE : S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (dmem_rvalid) begin
                    LoadDoneM    = 1'b1;
                    ReadDataM    = w_load_ext;
                    w_state_next = S_IDLE;
                end else if (w_timeout) begin
                    FaultM       = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    StallM = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr    <= '0;
            r_addr_lo <= 2'b00;
            r_funct3  <= 3'b000;
            r_we      <= 1'b0;
            r_be      <= 4'b0000;
            r_wdata   <= '0;
        end else if (w_capture) begin
            r_addr    <= {ALUResultM[XLEN-1:2], 2'b00};
            r_addr_lo <= ALUResultM[1:0];
            r_funct3  <= funct3M;
            r_we      <= w_is_store;
            r_be      <= w_be;
            r_wdata   <= w_wdata;
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: stimulus queues expected memory requests, load results
// and faults; a negedge monitor pops and compares them as the DUT presents them.
module tb_mem_stage_lsu;

    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWriteM;
    logic [2:0]  ResultSrcM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [2:0]  funct3M;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic [31:0] ReadDataM;
    logic        LoadDoneM;
    logic        StallM;
    logic        FaultM;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        int          kind;  // 0 request accepted, 1 load done, 2 fault
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
        logic        we;
    } exp_t;

    exp_t sb_q[$];

    mem_stage_lsu #(
        .XLEN            (32),
        .RESULT_SRC_LOAD (3'b001),
        .TIMEOUT_CYCLES  (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .MemWriteM   (MemWriteM),
        .ResultSrcM  (ResultSrcM),
        .ALUResultM  (ALUResultM),
        .WriteDataM  (WriteDataM),
        .funct3M     (funct3M),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_be     (dmem_be),
        .dmem_gnt    (dmem_gnt),
        .dmem_rvalid (dmem_rvalid),
        .dmem_rdata  (dmem_rdata),
        .ReadDataM   (ReadDataM),
        .LoadDoneM   (LoadDoneM),
        .StallM      (StallM),
        .FaultM      (FaultM)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int kind, input logic [31:0] addr, input logic [3:0] be,
                            input logic [31:0] data, input logic we);
        exp_t e;
        e.kind = kind;
        e.addr = addr;
        e.be   = be;
        e.data = data;
        e.we   = we;
        sb_q.push_back(e);
    endtask

    task automatic pop_check(input int kind);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL unexpected_event: got kind %0d, expected none at %0t", kind, $time);
        end else begin
            e = sb_q.pop_front();
            cmp("event_kind", 32'(kind), 32'(e.kind));
            if (e.kind == kind) begin
                if (kind == 0) begin
                    cmp("req_addr", dmem_addr, e.addr);
                    cmp("req_be", {28'd0, dmem_be}, {28'd0, e.be});
                    cmp("req_wdata", dmem_wdata, e.data);
                    cmp("req_we", {31'd0, dmem_we}, {31'd0, e.we});
                end else if (kind == 1) begin
                    cmp("load_data", ReadDataM, e.data);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (dmem_req && dmem_gnt) pop_check(0);
            if (LoadDoneM) pop_check(1);
            if (FaultM) pop_check(2);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        MemWriteM   = 1'b0;
        ResultSrcM  = 3'b000;
        ALUResultM  = 32'h0;
        WriteDataM  = 32'h0;
        funct3M     = 3'b000;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'h0;
    endtask

    // Non-access junk on the M inputs while the LSU works from its captured request.
    task automatic junk_inputs();
        MemWriteM  = 1'b0;
        ResultSrcM = 3'b000;
        ALUResultM = 32'hDEAD_BEEF;
        WriteDataM = 32'hFFFF_FFFF;
        funct3M    = 3'b010;
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] wd,
                            input logic [2:0] rs, input int gd, input logic [31:0] exp_addr,
                            input logic [3:0] exp_be, input logic [31:0] exp_wdata);
        push_exp(0, exp_addr, exp_be, exp_wdata, 1'b1);
        for (int c = 0; c <= gd; c++) begin
            if (c == 0) begin
                MemWriteM  = 1'b1;
                ResultSrcM = rs;
                ALUResultM = addr;
                WriteDataM = wd;
                funct3M    = f3;
            end else begin
                junk_inputs();
            end
            dmem_gnt = (c == gd);
            @(negedge clk);
            cmp("store_stall", {31'd0, StallM}, (c < gd) ? 32'd1 : 32'd0);
            if (c > 0) cmp("store_req_held", {31'd0, dmem_req}, 32'd1);
            tick();
        end
        idle_inputs();
    endtask

    task automatic do_load(input logic [31:0] addr, input logic [2:0] f3, input int gd,
                           input int rd, input logic [31:0] rdata, input logic [31:0] exp);
        int n;
        int stalls;
        n      = gd + 1 + rd;
        stalls = 0;
        push_exp(0, {addr[31:2], 2'b00}, 4'hF, 32'h0, 1'b0);
        push_exp(1, 32'h0, 4'h0, exp, 1'b0);
        for (int c = 0; c < n; c++) begin
            if (c == 0) begin
                MemWriteM  = 1'b0;
                ResultSrcM = 3'b001;
                ALUResultM = addr;
                WriteDataM = 32'h0;
                funct3M    = f3;
            end else begin
                junk_inputs();
            end
            dmem_gnt    = (c == gd);
            // Stray rvalid before the grant must be ignored.
            dmem_rvalid = (c == n - 1) || (c < gd);
            dmem_rdata  = (c == n - 1) ? rdata : 32'h5555_5555;
            @(negedge clk);
            if (c > 0 && c <= gd) begin
                cmp("load_req_held", {31'd0, dmem_req}, 32'd1);
                cmp("load_req_addr", dmem_addr, {addr[31:2], 2'b00});
            end
            if (c < n - 1) begin
                stalls += int'(StallM);
            end else begin
                cmp("load_done_stall", {31'd0, StallM}, 32'd0);
                cmp("load_done_flag", {31'd0, LoadDoneM}, 32'd1);
            end
            tick();
        end
        cmp("load_stall_cycles", 32'(stalls), 32'(n - 1));
        idle_inputs();
    endtask

    task automatic do_fault(input logic [31:0] addr, input logic [2:0] f3, input logic we);
        push_exp(2, 32'h0, 4'h0, 32'h0, 1'b0);
        MemWriteM  = we;
        ResultSrcM = we ? 3'b000 : 3'b001;
        ALUResultM = addr;
        WriteDataM = 32'h1234_5678;
        funct3M    = f3;
        dmem_gnt   = 1'b1;
        @(negedge clk);
        cmp("fault_no_req", {31'd0, dmem_req}, 32'd0);
        cmp("fault_stall", {31'd0, StallM}, 32'd0);
        cmp("fault_done", {31'd0, LoadDoneM}, 32'd0);
        cmp("fault_rdata", ReadDataM, 32'h0);
        tick();
        idle_inputs();
        @(negedge clk);
        cmp("fault_pulse_end", {31'd0, FaultM}, 32'd0);
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int stalls;
        idle_inputs();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        cmp("rst_req", {31'd0, dmem_req}, 32'd0);
        cmp("rst_addr", dmem_addr, 32'h0);
        cmp("rst_wdata", dmem_wdata, 32'h0);
        cmp("rst_be", {28'd0, dmem_be}, 32'h0);
        cmp("rst_stall", {31'd0, StallM}, 32'd0);
        cmp("rst_done", {31'd0, LoadDoneM}, 32'd0);
        cmp("rst_fault", {31'd0, FaultM}, 32'd0);
        cmp("rst_rdata", ReadDataM, 32'h0);
        tick();

        do_store(32'h0000_1003, 3'b000, 32'h0000_00A5, 3'b000, 0, 32'h0000_1000, 4'b1000,
                 32'hA5A5_A5A5);
        @(negedge clk);
        cmp("sb_back_idle", {31'd0, StallM}, 32'd0);
        tick();
        do_store(32'h0000_1006, 3'b001, 32'h1234_ABCD, 3'b000, 1, 32'h0000_1004, 4'b1100,
                 32'hABCD_ABCD);
        do_store(32'h0000_2000, 3'b010, 32'hCAFE_F00D, 3'b001, 0, 32'h0000_2000, 4'b1111,
                 32'hCAFE_F00D);
        do_store(32'h0000_2001, 3'b000, 32'h0000_0012, 3'b000, 2, 32'h0000_2000, 4'b0010,
                 32'h1212_1212);

        do_load(32'h0000_2002, 3'b001, 2, 3, 32'h8001_1234, 32'hFFFF_8001);
        do_load(32'h0000_0031, 3'b100, 0, 1, 32'h0000_F000, 32'h0000_00F0);
        do_load(32'h0000_0031, 3'b000, 0, 1, 32'h0000_F000, 32'hFFFF_FFF0);
        do_load(32'h0000_0040, 3'b101, 1, 1, 32'h7FFF_9ABC, 32'h0000_9ABC);
        do_load(32'h0000_0044, 3'b010, 0, 2, 32'h89AB_CDEF, 32'h89AB_CDEF);

        do_fault(32'h0000_4002, 3'b010, 1'b0);
        do_fault(32'h0000_0100, 3'b011, 1'b0);
        do_fault(32'h0000_1001, 3'b001, 1'b1);
        do_fault(32'h0000_0100, 3'b100, 1'b1);
        do_fault(32'h0000_0203, 3'b001, 1'b0);

        // Reset while a load sits in WAIT, then a late response.
        push_exp(0, 32'h0000_3000, 4'hF, 32'h0, 1'b0);
        ResultSrcM = 3'b001;
        ALUResultM = 32'h0000_3000;
        funct3M    = 3'b010;
        dmem_gnt   = 1'b1;
        tick();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset       = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h1234_5678;
        @(negedge clk);
        cmp("rstw_req", {31'd0, dmem_req}, 32'd0);
        cmp("rstw_done", {31'd0, LoadDoneM}, 32'd0);
        cmp("rstw_rdata", ReadDataM, 32'h0);
        cmp("rstw_stall", {31'd0, StallM}, 32'd0);
        cmp("rstw_addr", dmem_addr, 32'h0);
        cmp("rstw_be", {28'd0, dmem_be}, 32'h0);
        tick();
        idle_inputs();

        stalls     = 0;
        ResultSrcM = 3'b001;
        ALUResultM = 32'h0000_5000;
        funct3M    = 3'b010;
`ifdef LSU_TIMEOUT_EN
        push_exp(2, 32'h0, 4'h0, 32'h0, 1'b0);
        for (int c = 0; c <= int'(TO); c++) begin
            @(negedge clk);
            if (c < int'(TO)) begin
                stalls += int'(StallM);
            end else begin
                cmp("to_stall", {31'd0, StallM}, 32'd0);
                cmp("to_req", {31'd0, dmem_req}, 32'd0);
                cmp("to_fault", {31'd0, FaultM}, 32'd1);
            end
            tick();
            junk_inputs();
        end
        cmp("to_stall_cycles", 32'(stalls), 32'(TO));
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hFFFF_FFFF;
        @(negedge clk);
        cmp("to_stray_done", {31'd0, LoadDoneM}, 32'd0);
        cmp("to_stray_stall", {31'd0, StallM}, 32'd0);
        tick();
        idle_inputs();
`else
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            stalls += int'(StallM);
            tick();
            junk_inputs();
        end
        cmp("noto_stall_cycles", 32'(stalls), 32'd20);
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        cmp("noto_after_rst", {31'd0, StallM}, 32'd0);
        tick();
`endif

        repeat (3) tick();
        cmp("queue_empty", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
